gnand_unit: RTL and testbench
=============================

Name: gnand_unit

Overview:
- Bitwise 2-input NAND gate: a purely combinational output plus a registered copy.
- Includes lightweight built-in observation logic: truth-table coverage flags and an output toggle counter.
- Used as a basic logic primitive and self-checking gate cell in the ESC lab designs; the combinational path is the primary function.

Parameters:
- WIDTH, 1, number of independent NAND lanes (bitwise on a/b/y).
- CNT_W, 8, width of the saturating toggle counter.

Ports:
- clk  input  1  system clock; all registered state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational NAND, y = ~(a & b).
- y_q  output  WIDTH  y registered one cycle.
- y_all  output  1  combinational; 1 when every lane of y is 1 (no lane has a=b=1).
- cov  output  4  sticky coverage flags for lane 0; bit index = {a[0],b[0]}.
- cov_done  output  1  registered; 1 when cov == 4'b1111.
- tog_cnt  output  CNT_W  saturating count of clock cycles in which y_q changed value.

Behaviour:
- Interface: one clock (clk); reset (rst_n) is synchronous and active-low.
- y:
  - zero-latency combinational; never depends on clk or rst_n.
  - valid for every a/b combination, including during reset.
  - truth table per lane: 00→1, 01→1, 10→1, 11→0.
- y_all = &y, combinational.
- Reset (rst_n=0 at rising clk):
  - y_q ← all ones (the NAND of 0,0).
  - cov ← 4'b0000.
  - cov_done ← 0.
  - tog_cnt ← 0.
- Reset takes priority over all other updates. Reset mid-operation clears coverage and counter on that edge; y is unaffected.
- Normal operation (rst_n=1), each rising clk:
  - y_q ← ~(a & b); latency exactly 1 cycle.
  - cov[{a[0],b[0]}] ← 1. Bits stay set until reset; no other clearing path.
  - cov_done ← (next value of cov == 4'b1111), i.e. it goes high on the same edge the last flag sets.
  - tog_cnt increments by 1 if the new y_q differs from the current y_q in any bit.
  - tog_cnt saturates at 2^CNT_W−1; it holds at the maximum and never wraps.
- The first edge after reset release compares against the reset value all-ones. Example: a=b=1 at the first edge gives y_q=0 and tog_cnt=1.
- X/Z inputs: no special handling required; the combinational NAND follows standard 4-state rules.
- No handshake and no backpressure; inputs are sampled on every edge.

Test Plan:
- WIDTH=1, combinational sweep: apply a,b = 00, 01, 10, 11 in turn, 10 time units apart, with no clock edge required -> y = 1, 1, 1, 0 immediately; y_all tracks y.
- Registered path: rst_n=0 for one edge, then y_q=1. Release reset, drive a=1,b=1 -> y_q=0 after exactly one edge; tog_cnt=1.
- Coverage: after reset apply 00, 01, 10, 11 on consecutive edges -> cov = 0001, 0011, 0111, 1111; cov_done=1 on the fourth edge.
- Reset mid-operation: with cov=1111 and tog_cnt=3, assert rst_n=0 for one edge -> cov=0000, cov_done=0, tog_cnt=0, y_q=1. y remains equal to ~(a&b) throughout.
- Saturation: CNT_W=2, alternate a=b=1 and a=b=0 for 6 edges -> tog_cnt goes 1, 2, 3, 3, 3, 3.
- WIDTH=4: a=4'b1100, b=4'b1010 -> y=4'b0111, y_all=0. With a=4'b0000 -> y=4'b1111, y_all=1.

Source files
------------

// File: rtl/gnand_unit.sv
// Bitwise NAND with a registered copy, lane-0 truth-table coverage and a saturating y_q toggle counter.
// Latency: y and y_all are combinational; y_q, cov, cov_done and tog_cnt update one clk edge after inputs.
// Backpressure: none; a and b are sampled on every rising edge.
module gnand_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_all,
    output logic [3:0]       cov,
    output logic             cov_done,
    output logic [CNT_W-1:0] tog_cnt
);

    logic [WIDTH-1:0] yreg_d, yreg_q;
    logic [3:0]       cov_d, cov_q;
    logic             done_d, done_q;
    logic [CNT_W-1:0] tog_d, tog_q;
    logic [1:0]       cov_idx;

    assign y     = ~(a & b);
    assign y_all = &y;

    always_comb begin
        yreg_d  = y;
        cov_idx = {a[0], b[0]};
        cov_d   = cov_q | (4'b0001 << cov_idx);
        done_d  = (cov_d == 4'b1111);
        tog_d   = tog_q;
        // Compare against the current register so the first edge after reset sees all-ones.
        if ((yreg_d != yreg_q) && (tog_q != {CNT_W{1'b1}})) begin
            tog_d = tog_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yreg_q <= {WIDTH{1'b1}};
            cov_q  <= 4'b0000;
            done_q <= 1'b0;
            tog_q  <= '0;
        end else begin
            yreg_q <= yreg_d;
            cov_q  <= cov_d;
            done_q <= done_d;
            tog_q  <= tog_d;
        end
    end

    assign y_q      = yreg_q;
    assign cov      = cov_q;
    assign cov_done = done_q;
    assign tog_cnt  = tog_q;

endmodule

// File: tb/tb_gnand_unit.sv
// Directed bench for gnand_unit: one WIDTH=1/CNT_W=8 instance, one CNT_W=2 instance, one WIDTH=4 instance.
module tb_gnand_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Instance 1: WIDTH=1, CNT_W=8
    logic       a1, b1, y1, yq1, yall1, cdone1;
    logic [3:0] cov1;
    logic [7:0] tog1;
    gnand_unit #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .y(y1), .y_q(yq1), .y_all(yall1),
        .cov(cov1), .cov_done(cdone1), .tog_cnt(tog1)
    );

    // Instance 2: WIDTH=1, CNT_W=2 (saturation)
    logic       a2, b2, y2, yq2, yall2, cdone2;
    logic [3:0] cov2;
    logic [1:0] tog2;
    gnand_unit #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .y(y2), .y_q(yq2), .y_all(yall2),
        .cov(cov2), .cov_done(cdone2), .tog_cnt(tog2)
    );

    // Instance 3: WIDTH=4, CNT_W=8
    logic [3:0] a4, b4, y4, yq4, cov4;
    logic       yall4, cdone4;
    logic [7:0] tog4;
    gnand_unit #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .y(y4), .y_q(yq4), .y_all(yall4),
        .cov(cov4), .cov_done(cdone4), .tog_cnt(tog4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u1(input string tag, input logic yq, input logic [3:0] cv,
                          input logic cd, input logic [7:0] tg);
        chk({tag, ".y_q"},     32'(yq1),    32'(yq));
        chk({tag, ".cov"},     32'(cov1),   32'(cv));
        chk({tag, ".cov_done"}, 32'(cdone1), 32'(cd));
        chk({tag, ".tog_cnt"}, 32'(tog1),   32'(tg));
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a2 = 1'b0; b2 = 1'b0;
        a4 = 4'b0000; b4 = 4'b0000;

        // Reset state
        edge1();
        chk_u1("reset", 1'b1, 4'b0000, 1'b0, 8'd0);
        chk("reset.u2.tog", 32'(tog2), 32'd0);

        // Combinational sweep, valid during reset and without an edge
        a1 = 0; b1 = 0; #1; chk("comb00.y", 32'(y1), 32'd1); chk("comb00.y_all", 32'(yall1), 32'd1);
        a1 = 0; b1 = 1; #1; chk("comb01.y", 32'(y1), 32'd1); chk("comb01.y_all", 32'(yall1), 32'd1);
        a1 = 1; b1 = 0; #1; chk("comb10.y", 32'(y1), 32'd1); chk("comb10.y_all", 32'(yall1), 32'd1);
        a1 = 1; b1 = 1; #1; chk("comb11.y", 32'(y1), 32'd0); chk("comb11.y_all", 32'(yall1), 32'd0);

        // Reset still asserted with a=b=1: y_q stays all-ones
        edge1();
        chk_u1("rst_hold", 1'b1, 4'b0000, 1'b0, 8'd0);

        // Release with a=b=1: y_q=0 after exactly one edge, tog_cnt=1
        rst_n = 1'b1;
        #1; chk("pre_edge.y_q", 32'(yq1), 32'd1);
        edge1();
        chk_u1("first11", 1'b0, 4'b1000, 1'b0, 8'd1);

        // Coverage sequence after a fresh reset
        rst_n = 1'b0; a1 = 0; b1 = 0;
        edge1();
        chk_u1("rst2", 1'b1, 4'b0000, 1'b0, 8'd0);
        rst_n = 1'b1;
        a1 = 0; b1 = 0; edge1(); chk_u1("cov00", 1'b1, 4'b0001, 1'b0, 8'd0);
        a1 = 0; b1 = 1; edge1(); chk_u1("cov01", 1'b1, 4'b0011, 1'b0, 8'd0);
        a1 = 1; b1 = 0; edge1(); chk_u1("cov10", 1'b1, 4'b0111, 1'b0, 8'd0);
        a1 = 1; b1 = 1; edge1(); chk_u1("cov11", 1'b0, 4'b1111, 1'b1, 8'd1);
        a1 = 0; b1 = 0; edge1(); chk_u1("tog2",  1'b1, 4'b1111, 1'b1, 8'd2);
        a1 = 1; b1 = 1; edge1(); chk_u1("tog3",  1'b0, 4'b1111, 1'b1, 8'd3);

        // Mid-operation reset: state clears, y untouched
        rst_n = 1'b0;
        #1; chk("midrst.y_before", 32'(y1), 32'd0);
        edge1();
        chk_u1("midrst", 1'b1, 4'b0000, 1'b0, 8'd0);
        chk("midrst.y_after", 32'(y1), 32'd0);

        // Saturation on CNT_W=2 instance
        rst_n = 1'b1;
        a2 = 1; b2 = 1; edge1(); chk("sat1.tog", 32'(tog2), 32'd1); chk("sat1.y_q", 32'(yq2), 32'd0);
        a2 = 0; b2 = 0; edge1(); chk("sat2.tog", 32'(tog2), 32'd2);
        a2 = 1; b2 = 1; edge1(); chk("sat3.tog", 32'(tog2), 32'd3);
        a2 = 0; b2 = 0; edge1(); chk("sat4.tog", 32'(tog2), 32'd3);
        a2 = 1; b2 = 1; edge1(); chk("sat5.tog", 32'(tog2), 32'd3);
        a2 = 0; b2 = 0; edge1(); chk("sat6.tog", 32'(tog2), 32'd3); chk("sat6.y_q", 32'(yq2), 32'd1);

        // WIDTH=4 lanes
        a4 = 4'b1100; b4 = 4'b1010; #1;
        chk("w4a.y", 32'(y4), 32'h7);
        chk("w4a.y_all", 32'(yall4), 32'd0);
        edge1();
        chk("w4a.y_q", 32'(yq4), 32'h7);
        chk("w4a.tog", 32'(tog4), 32'd1);
        a4 = 4'b0000; #1;
        chk("w4b.y", 32'(y4), 32'hF);
        chk("w4b.y_all", 32'(yall4), 32'd1);
        chk("w4b.y_q_held", 32'(yq4), 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
